sap_controller: RTL and testbench
=================================

Name: sap_controller

Overview:
- Controller-sequencer for the SAP-class 8-bit datapath: program counter, MAR, 16x8 RAM, instruction register, accumulator, ALU, B register and output register.
- Runs a 6-state T-ring and decodes the IR opcode into a 12-bit control word plus a halt flag.
- Gates all RAM reads against the RAM's run_prog / CE programming interface.
- Sits beside the datapath; its outputs drive every load/enable pin.

Parameters:
- OP_W, 4, opcode width (IR upper nibble).
- CW_W, 12, control-word width: {cp, ep, lm_n, CE, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n}, bit 11 to bit 0.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous active-high reset.
- run_prog  input  1  1 = execute, 0 = programming mode (RAM owned by loader).
- opcode  input  OP_W  IR[7:4].
- con  output  CW_W  control word (active-low fields end in _n; CE is active-low RAM enable).
- lp  output  1  load PC from bus (JMP only; constant 0 when feature absent).
- hlt  output  1  halted flag; clock-gating request to datapath.
- t_state  output  6  one-hot ring state, T1 = 6'b000001.

Behaviour:
- Reset (async): t_state = T1, hlt = 0, lp = 0. con is a decode, so it shows the T1 word 12'h5E3 while running. The idle word is 12'h3E3.
- Ring: T1→T2→…→T6→T1, one step per rising clk. Instruction latency is 6 cycles.
- con is a combinational decode of (t_state, opcode). No extra register stage.
- Fetch words, opcode-independent:
  - T1 = 5E3 (ep, lm_n).
  - T2 = BE3 (cp).
  - T3 = 263 (CE, li_n).
- LDA (0000): T4 = 1A3, T5 = 2C3, T6 = 3E3.
- ADD (0001): T4 = 1A3, T5 = 2E1, T6 = 3C7.
- SUB (0010): T4 = 1A3, T5 = 2E1, T6 = 3CF.
- OUT (1110): T4 = 3F2, T5 = 3E3, T6 = 3E3.
- HLT (1111):
  - At T4, con = 3E3 and hlt sets on that rising edge.
  - While hlt = 1, t_state freezes at T4 and con = 3E3.
  - hlt clears only on rst or run_prog = 0.
- Any other opcode: NOP; T4–T6 = 3E3.
- run_prog = 0:
  - Synchronously forces t_state = T1 and clears hlt.
  - con is forced to 3E3 so CE stays high and the RAM is free for programming writes.
  - On the first rising edge after run_prog returns to 1, fetch starts from T1.
- run_prog falling mid-instruction aborts the instruction; there is no partial-state recovery.
- rst mid-instruction aborts immediately, asynchronously.
- Simultaneous rst and run_prog edge: rst wins.
- Opcode changes outside T4–T6 have no effect. IR is loaded at T3, so the opcode is stable from T4.

Optional Feature:
- Macro: SAP_JMP_EN.
- Defined: opcode 0011 = JMP.
  - T4: con = 3A3 (ei_n) and lp = 1 for that cycle.
  - T5 and T6: con = 3E3.
- Undefined: 0011 decodes as NOP; lp is tied 0.

Decomposition:
- Package sap_pkg holds:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_JMP, OP_OUT, OP_HLT);
  - control-word bit-index constants;
  - named control words (CW_IDLE = 12'h3E3, CW_FETCH1/2/3, etc.);
  - T-state one-hot constants.
- Sub-module sap_ring_counter:
  - 6-bit one-hot ring with async rst, synchronous force-to-T1 and hold inputs.
- The decode stays in sap_controller.

Test Plan:
- Reset then release, run_prog = 1, opcode = 0000 → con sequence 5E3, BE3, 263, 1A3, 2C3, 3E3, then back to 5E3; hlt = 0.
- opcode = 0010 over one instruction → T5 = 2E1, T6 = 3CF. With opcode = 0001 → T6 = 3C7.
- opcode = 1111 → hlt = 1 after the T4 edge. t_state stays 6'b001000 and con = 3E3 for 20 cycles. Pulsing run_prog low clears hlt and restarts at T1.
- run_prog driven low during T5 of an ADD → next edge t_state = T1, con = 3E3 (CE = 1) while low. Fetch resumes on return.
- Assert rst asynchronously mid-T3 → t_state = T1, hlt = 0 immediately without a clock edge.
- SAP_JMP_EN defined, opcode = 0011 → T4 con = 3A3 and lp = 1 for exactly one cycle. Undefined → T4 = 3E3 and lp = 0.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared constants for the SAP controller: opcodes, control-word layout,
// named control words and the one-hot T-ring states.
package sap_pkg;

    localparam int OP_W = 4;
    localparam int CW_W = 12;

    localparam logic [OP_W-1:0] OP_LDA = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_JMP = 4'h3;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    localparam int CW_CP   = 11;
    localparam int CW_EP   = 10;
    localparam int CW_LM_N = 9;
    localparam int CW_CE   = 8;
    localparam int CW_LI_N = 7;
    localparam int CW_EI_N = 6;
    localparam int CW_LA_N = 5;
    localparam int CW_EA   = 4;
    localparam int CW_SU   = 3;
    localparam int CW_EU   = 2;
    localparam int CW_LB_N = 1;
    localparam int CW_LO_N = 0;

    typedef logic [CW_W-1:0] cw_t;

    localparam cw_t CW_IDLE   = 12'h3E3;
    localparam cw_t CW_FETCH1 = 12'h5E3;
    localparam cw_t CW_FETCH2 = 12'hBE3;
    localparam cw_t CW_FETCH3 = 12'h263;
    localparam cw_t CW_MEM4   = 12'h1A3;
    localparam cw_t CW_LDA5   = 12'h2C3;
    localparam cw_t CW_ALU5   = 12'h2E1;
    localparam cw_t CW_ADD6   = 12'h3C7;
    localparam cw_t CW_SUB6   = 12'h3CF;
    localparam cw_t CW_OUT4   = 12'h3F2;
    localparam cw_t CW_JMP4   = 12'h3A3;

    typedef enum logic [5:0] {
        ST_T1 = 6'b000001,
        ST_T2 = 6'b000010,
        ST_T3 = 6'b000100,
        ST_T4 = 6'b001000,
        ST_T5 = 6'b010000,
        ST_T6 = 6'b100000
    } t_state_e;

endpackage

// File: rtl/sap_controller_if.sv
// Controller-side bundle: mode/opcode in, control word, PC load,
// halt flag and ring state out. Master = datapath side, slave = controller.
interface sap_controller_if;
    import sap_pkg::*;

    logic            run_prog;
    logic [OP_W-1:0] opcode;
    logic [CW_W-1:0] con;
    logic            lp;
    logic            hlt;
    logic [5:0]      t_state;

    modport master (
        output run_prog, opcode,
        input  con, lp, hlt, t_state
    );

    modport slave (
        input  run_prog, opcode,
        output con, lp, hlt, t_state
    );

endinterface

// File: rtl/sap_ring_counter.sv
// Six-state one-hot T-ring with async reset, synchronous force-to-T1
// and hold.
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_force_t1,
    input  logic     i_hold,
    output t_state_e o_state
);

    t_state_e r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_T1;
        end else if (i_force_t1) begin
            r_state <= ST_T1;
        end else if (!i_hold) begin
            case (r_state)
                ST_T1:   r_state <= ST_T2;
                ST_T2:   r_state <= ST_T3;
                ST_T3:   r_state <= ST_T4;
                ST_T4:   r_state <= ST_T5;
                ST_T5:   r_state <= ST_T6;
                ST_T6:   r_state <= ST_T1;
                default: r_state <= ST_T1;
            endcase
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/sap_controller.sv
// SAP controller-sequencer: T-ring plus opcode decode into the control word.
// Build with SAP_JMP_EN defined to add JMP (opcode 0011, pulses lp at T4).
module sap_controller
    import sap_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    sap_controller_if.slave  bus
);

    t_state_e        w_t_state;
    logic [OP_W-1:0] w_op;
    logic            w_hlt_set;
    logic            w_hold;
    logic            w_force;
    cw_t             w_con;
    logic            w_lp;
    logic            r_hlt;

    assign w_op      = bus.opcode;
    assign w_force   = !bus.run_prog;
    assign w_hlt_set = bus.run_prog && !r_hlt &&
                       (w_t_state == ST_T4) && (w_op == OP_HLT);
    // Halting freezes the ring on T4 from the very edge that sets hlt.
    assign w_hold    = r_hlt | w_hlt_set;

    sap_ring_counter u_ring (
        .clk        (clk),
        .rst        (rst),
        .i_force_t1 (w_force),
        .i_hold     (w_hold),
        .o_state    (w_t_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hlt <= 1'b0;
        end else if (!bus.run_prog) begin
            r_hlt <= 1'b0;
        end else if (w_hlt_set) begin
            r_hlt <= 1'b1;
        end
    end

    // Programming mode and halt both park on the idle word (CE high).
    always_comb begin
        w_con = CW_IDLE;
        w_lp  = 1'b0;
        if (bus.run_prog && !r_hlt) begin
            case (w_t_state)
                ST_T1: w_con = CW_FETCH1;
                ST_T2: w_con = CW_FETCH2;
                ST_T3: w_con = CW_FETCH3;
                ST_T4: begin
                    case (w_op)
                        OP_LDA, OP_ADD, OP_SUB: w_con = CW_MEM4;
                        OP_OUT:                 w_con = CW_OUT4;
`ifdef SAP_JMP_EN
                        OP_JMP: begin
                            w_con = CW_JMP4;
                            w_lp  = 1'b1;
                        end
`endif
                        default: w_con = CW_IDLE;
                    endcase
                end
                ST_T5: begin
                    case (w_op)
                        OP_LDA:         w_con = CW_LDA5;
                        OP_ADD, OP_SUB: w_con = CW_ALU5;
                        default:        w_con = CW_IDLE;
                    endcase
                end
                ST_T6: begin
                    case (w_op)
                        OP_ADD:  w_con = CW_ADD6;
                        OP_SUB:  w_con = CW_SUB6;
                        default: w_con = CW_IDLE;
                    endcase
                end
                default: w_con = CW_IDLE;
            endcase
        end
    end

    assign bus.con     = w_con;
    assign bus.lp      = w_lp;
    assign bus.hlt     = r_hlt;
    assign bus.t_state = w_t_state;

endmodule

// File: tb/tb_sap_controller.sv
// Self-checking bench for sap_controller: vector table, corner-case
// sequences and randomized run against a phase/halt reference model.
module tb_sap_controller;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sap_controller_if bus ();

    sap_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        run;
        logic [3:0]  op;
        logic [11:0] con;
        logic [5:0]  ts;
        logic        hlt;
    } vec_t;

    vec_t        tv[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          k;
    bit          halted;
    bit          jmp_en;
    logic [11:0] exec_tab [16][3];
    logic [11:0] jmp_con;
    logic        jmp_lp;

    task automatic check(input string name, input logic [11:0] got,
                         input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [11:0] c,
                              input logic [5:0] t, input logic h);
        check({tag, " con"}, bus.con, c);
        check({tag, " t_state"}, {6'b0, bus.t_state}, {6'b0, t});
        check({tag, " hlt"}, {11'b0, bus.hlt}, {11'b0, h});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.run_prog = 1'b1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        k = 1;
        halted = 1'b0;
    endtask

    function automatic logic [11:0] exp_con(int ph, logic [3:0] op,
                                            logic run, bit h);
        if (!run || h) return 12'h3E3;
        case (ph)
            1: return 12'h5E3;
            2: return 12'hBE3;
            3: return 12'h263;
            default: return exec_tab[op][ph-4];
        endcase
    endfunction

    task automatic check_model(input string tag);
        logic [11:0] ts_exp;
        logic        lp_exp;
        ts_exp = 12'(1 << (k - 1));
        lp_exp = bus.run_prog && !halted && k == 4 &&
                 bus.opcode == 4'h3 && jmp_en;
        check({tag, " con"}, bus.con,
              exp_con(k, bus.opcode, bus.run_prog, halted));
        check({tag, " t_state"}, {6'b0, bus.t_state}, ts_exp);
        check({tag, " hlt"}, {11'b0, bus.hlt}, {11'b0, halted});
        check({tag, " lp"}, {11'b0, bus.lp}, {11'b0, lp_exp});
    endtask

    task automatic clock_model();
        logic       run;
        logic [3:0] op;
        run = bus.run_prog;
        op  = bus.opcode;
        @(posedge clk);
        if (!run) begin
            k = 1;
            halted = 1'b0;
        end else if (halted) begin
            k = k;
        end else if (k == 4 && op == 4'hF) begin
            halted = 1'b1;
        end else begin
            k = (k % 6) + 1;
        end
        #1;
    endtask

    task automatic push_instr(input logic [3:0] fop, input logic [3:0] op,
                              input logic [11:0] c4, input logic [11:0] c5,
                              input logic [11:0] c6);
        tv.push_back('{1'b1, fop, 12'h5E3, 6'b000001, 1'b0});
        tv.push_back('{1'b1, fop, 12'hBE3, 6'b000010, 1'b0});
        tv.push_back('{1'b1, fop, 12'h263, 6'b000100, 1'b0});
        tv.push_back('{1'b1, op,  c4,      6'b001000, 1'b0});
        tv.push_back('{1'b1, op,  c5,      6'b010000, 1'b0});
        tv.push_back('{1'b1, op,  c6,      6'b100000, 1'b0});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef SAP_JMP_EN
        jmp_en = 1'b1;
`else
        jmp_en = 1'b0;
`endif
        for (int i = 0; i < 16; i++) begin
            exec_tab[i] = '{12'h3E3, 12'h3E3, 12'h3E3};
        end
        exec_tab[0]  = '{12'h1A3, 12'h2C3, 12'h3E3};
        exec_tab[1]  = '{12'h1A3, 12'h2E1, 12'h3C7};
        exec_tab[2]  = '{12'h1A3, 12'h2E1, 12'h3CF};
        exec_tab[14] = '{12'h3F2, 12'h3E3, 12'h3E3};
        if (jmp_en) exec_tab[3] = '{12'h3A3, 12'h3E3, 12'h3E3};
        jmp_con = jmp_en ? 12'h3A3 : 12'h3E3;
        jmp_lp  = jmp_en;

        push_instr(4'h0, 4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
        push_instr(4'hF, 4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
        push_instr(4'h2, 4'h2, 12'h1A3, 12'h2E1, 12'h3CF);
        push_instr(4'h1, 4'h1, 12'h1A3, 12'h2E1, 12'h3C7);
        push_instr(4'hE, 4'hE, 12'h3F2, 12'h3E3, 12'h3E3);
        push_instr(4'h5, 4'h5, 12'h3E3, 12'h3E3, 12'h3E3);
        tv.push_back('{1'b1, 4'h0, 12'h5E3, 6'b000001, 1'b0});

        rst = 1'b1;
        bus.run_prog = 1'b1;
        bus.opcode = 4'h0;
        step();
        step();
        expect_out("reset", 12'h5E3, 6'b000001, 1'b0);
        check("reset lp", {11'b0, bus.lp}, 12'h000);
        rst = 1'b0;

        foreach (tv[i]) begin
            bus.run_prog = tv[i].run;
            bus.opcode = tv[i].op;
            #1;
            expect_out($sformatf("vec%0d", i), tv[i].con, tv[i].ts, tv[i].hlt);
            @(posedge clk);
            #1;
        end

        // Halt, hold for 20 cycles, release via run_prog.
        do_reset();
        bus.opcode = 4'hF;
        repeat (3) step();
        expect_out("hlt T4", 12'h3E3, 6'b001000, 1'b0);
        step();
        expect_out("hlt set", 12'h3E3, 6'b001000, 1'b1);
        bus.opcode = 4'h0;
        for (int i = 0; i < 20; i++) begin
            step();
            expect_out($sformatf("hlt hold%0d", i), 12'h3E3, 6'b001000, 1'b1);
        end
        bus.run_prog = 1'b0;
        #1;
        check("hlt prog con", bus.con, 12'h3E3);
        step();
        expect_out("hlt cleared", 12'h3E3, 6'b000001, 1'b0);
        bus.run_prog = 1'b1;
        #1;
        check("hlt resume T1", bus.con, 12'h5E3);
        step();
        expect_out("hlt resume T2", 12'hBE3, 6'b000010, 1'b0);

        // run_prog low during T5 of ADD.
        do_reset();
        bus.opcode = 4'h1;
        repeat (4) step();
        expect_out("add T5", 12'h2E1, 6'b010000, 1'b0);
        bus.run_prog = 1'b0;
        #1;
        check("abort con", bus.con, 12'h3E3);
        step();
        expect_out("abort T1", 12'h3E3, 6'b000001, 1'b0);
        check("abort CE", {11'b0, bus.con[8]}, 12'h001);
        step();
        expect_out("abort held", 12'h3E3, 6'b000001, 1'b0);
        bus.run_prog = 1'b1;
        #1;
        check("abort resume T1", bus.con, 12'h5E3);
        step();
        expect_out("abort resume T2", 12'hBE3, 6'b000010, 1'b0);

        // Async reset mid-T3, and async reset out of halt.
        do_reset();
        bus.opcode = 4'h2;
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        expect_out("async T3", 12'h5E3, 6'b000001, 1'b0);
        rst = 1'b0;
        do_reset();
        bus.opcode = 4'hF;
        repeat (4) step();
        check("async pre hlt", {11'b0, bus.hlt}, 12'h001);
        #2;
        rst = 1'b1;
        #1;
        expect_out("async hlt", 12'h5E3, 6'b000001, 1'b0);
        rst = 1'b0;

        // JMP (or NOP when the feature is absent).
        do_reset();
        bus.opcode = 4'h3;
        repeat (3) step();
        check("jmp T4 con", bus.con, jmp_con);
        check("jmp T4 lp", {11'b0, bus.lp}, {11'b0, jmp_lp});
        step();
        expect_out("jmp T5", 12'h3E3, 6'b010000, 1'b0);
        check("jmp T5 lp", {11'b0, bus.lp}, 12'h000);

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.run_prog = ($urandom_range(0, 15) != 0);
            case ($urandom_range(0, 7))
                0: bus.opcode = 4'h0;
                1: bus.opcode = 4'h1;
                2: bus.opcode = 4'h2;
                3: bus.opcode = 4'h3;
                4: bus.opcode = 4'hE;
                5: bus.opcode = 4'hF;
                default: bus.opcode = 4'($urandom_range(0, 15));
            endcase
            #1;
            check_model($sformatf("rand%0d", i));
            clock_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
